fc_flatten_dense: RTL and testbench
===================================

// Module: fc_flatten_dense
// PURPOSE
//  Dense (fully-connected) stage downstream of the conv/max-pool engine. After the engine finishes,
//  reads all 1024 pooled features (32x32, layer-1 memory), multiplies them by per-neuron weights,
//  adds bias, rounds, saturates, optionally applies ReLU and writes one value per neuron to the
//  layer-2 memory. Sole master of the shared layer-memory port while busy.
// PARAMETERS
//  NUM_NEURONS  2    output neurons, processed sequentially (1..4)
//  RELU_EN      1    1: clamp negative results to 0
//  FEAT_N       1024 features per neuron (fixed by 32x32 pool map)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  reset      in   1   asynchronous, active-low reset
//  ready      in   1   start request, sampled only in IDLE
//  busy       out  1   high from cycle after accepted ready until done
//  done       out  1   one-cycle pulse after last neuron written
//  crd        out  1   layer-memory read enable
//  caddr_rd   out  12  read address (feature index, 0..1023)
//  cdata_rd   in   20  signed Q4.16 feature, valid 1 cycle after crd
//  cwr        out  1   layer-memory write enable
//  caddr_wr   out  12  write address (= neuron index)
//  cdata_wr   out  20  signed Q4.16 result
//  csel       out  3   3'b011 while reading layer 1, 3'b101 while writing layer 2, else 3'b000
//  waddr      out  12  weight ROM address {neuron[1:0], feature[9:0]}
//  wdata      in   20  signed Q4.16 weight, valid 1 cycle after waddr
//  bias_data  in   20  signed Q4.16 bias of neuron waddr[11:10], combinational
// BEHAVIOUR
//  Reset: busy=0, done=0, crd=0, cwr=0, csel=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, waddr=0;
//   accumulator, counters cleared, FSM->IDLE. Reset mid-operation aborts; no partial write later.
//  FSM: IDLE -(ready)-> FETCH -(1024 reads issued)-> DRAIN -(2 cycles)-> WRITE (1 cycle)
//   -> FETCH for next neuron, or DONE after neuron NUM_NEURONS-1; DONE (1 cycle, done=1) -> IDLE.
//  ready while busy ignored. ready held high in IDLE after DONE restarts a new pass.
//  FETCH: one read per cycle, crd=1, caddr_rd=waddr[9:0]=k, k=0..1023, no bubbles.
//  Pipeline: cycle t issue k; t+1 cdata_rd/wdata valid, product registered; t+2 accumulated.
//  Product 20x20 signed -> 40b Q8.32; accumulator 50b signed, cleared at neuron start, never wraps.
//  Result: s = acc + (sign-extended bias<<16) + (1<<15); r = s>>>16 (arithmetic, round half up).
//   r > 20'h7FFFF -> 20'h7FFFF; r < -2^19 -> 20'h80000; then if RELU_EN and r<0 -> 0.
//  WRITE: cwr=1, csel=3'b101, caddr_wr=neuron, cdata_wr=result for exactly one cycle.
//  Per-neuron latency: 1024 FETCH + 2 DRAIN + 1 WRITE = 1027 cycles; total busy =
//   1027*NUM_NEURONS + 1 (DONE) cycles.
//  crd and cwr never high in the same cycle; csel=0 in IDLE/DRAIN/DONE.
// STRUCTURE
//  Shared package: FSM state encodings, CSEL_L1=3'b011, CSEL_L2=3'b101, Q4.16 width (20), frac
//   bits (16), ACC_W=50, SAT_MAX/SAT_MIN constants.
//  One sub-module: fc_mac_round (registered multiply, accumulate, bias add, round, saturate, ReLU);
//   top holds FSM, address counters and memory-port drive.
// TESTING
//  1 all features 0, bias 20'h01310 -> each neuron writes 20'h01310 at caddr_wr=neuron.
//  2 feature[0]=20'h10000, weight[0]=20'h08000, rest 0, bias 0 -> cdata_wr=20'h08000.
//  3 feature[5]=20'h00001, weight[5]=20'h08000 (product 0.5 LSB), bias 0 -> cdata_wr=20'h00001.
//  4 all features/weights 20'h7FFFF -> 20'h7FFFF; weights 20'h80001, RELU_EN=1 -> 0, RELU_EN=0 -> 20'h80000.
//  5 ready pulse, count cycles: busy high exactly 2055 cycles (NUM_NEURONS=2), done one pulse,
//   caddr_rd walks 0..1023 contiguously, crd/cwr never overlap.
//  6 reset low at feature 500 of neuron 0 -> all outputs reset next cycle, no cwr; restart gives
//   results identical to scenario 1.

Source files
------------

// File: rtl/fc_flatten_dense_pkg.sv
// rtl/fc_flatten_dense_pkg.sv - shared constants, FSM encoding and rounding helper for the dense stage
package fc_flatten_dense_pkg;

  localparam int Q_W    = 20;
  localparam int FRAC_W = 16;
  localparam int PROD_W = 2 * Q_W;
  localparam int ACC_W  = 50;
  localparam int ADDR_W = 12;
  localparam int FEAT_N = 1024;

  localparam logic [2:0] CSEL_OFF = 3'b000;
  localparam logic [2:0] CSEL_L1  = 3'b011;
  localparam logic [2:0] CSEL_L2  = 3'b101;

  localparam logic [Q_W-1:0] SAT_MAX = 20'h7FFFF;
  localparam logic [Q_W-1:0] SAT_MIN = 20'h80000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN1,
    S_DRAIN2,
    S_WRITE,
    S_DONE
  } state_e;

  // Q8.32 accumulator + Q4.16 bias -> Q4.16, round half up, saturate, optional ReLU.
  function automatic logic [Q_W-1:0] round_sat(input logic [ACC_W-1:0] acc,
                                               input logic [Q_W-1:0]   bias,
                                               input logic             relu);
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] r;
    logic [Q_W-1:0]        res;
    s = {acc[ACC_W-1], acc}
      + {{(ACC_W+1-Q_W-FRAC_W){bias[Q_W-1]}}, bias, {FRAC_W{1'b0}}}
      + {{(ACC_W+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    r = s >>> FRAC_W;
    if (r[ACC_W:Q_W-1] != {(ACC_W-Q_W+2){r[ACC_W]}}) begin
      res = r[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      res = r[Q_W-1:0];
    end
    if (relu && res[Q_W-1]) begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_flatten_dense_if.sv
// rtl/fc_flatten_dense_if.sv - start handshake, layer-memory port and weight/bias ROM port
interface fc_flatten_dense_if;
  import fc_flatten_dense_pkg::*;

  logic              ready;
  logic              busy;
  logic              done;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [Q_W-1:0]    cdata_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [Q_W-1:0]    cdata_wr;
  logic [2:0]        csel;
  logic [ADDR_W-1:0] waddr;
  logic [Q_W-1:0]    wdata;
  logic [Q_W-1:0]    bias_data;

  modport master (
    input  ready, cdata_rd, wdata, bias_data,
    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel, waddr
  );

  modport slave (
    output ready, cdata_rd, wdata, bias_data,
    input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel, waddr
  );

endinterface

// File: rtl/fc_flatten_dense_mac_round.sv
// rtl/fc_flatten_dense_mac_round.sv - registered multiply, accumulate and bias/round/saturate/ReLU
module fc_mac_round
  import fc_flatten_dense_pkg::*;
#(
  parameter bit RELU_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_i,
  input  logic                  clear_i,
  input  logic signed [Q_W-1:0] feat_i,
  input  logic signed [Q_W-1:0] wgt_i,
  input  logic        [Q_W-1:0] bias_i,
  output logic        [Q_W-1:0] result_o
);

  logic                     v1_q;
  logic                     pv_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  always_comb begin
    acc_d = acc_q;
    if (pv_q) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    end
  end

  // Result looks through the in-flight last product so it is ready in the final drain cycle.
  assign result_o = round_sat(acc_d, bias_i, RELU_EN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      pv_q   <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      v1_q   <= issue_i;
      pv_q   <= v1_q;
      prod_q <= PROD_W'(feat_i) * PROD_W'(wgt_i);
      acc_q  <= clear_i ? '0 : acc_d;
    end
  end

endmodule

// File: rtl/fc_flatten_dense.sv
// rtl/fc_flatten_dense.sv - dense layer sequencer: feature fetch, drain, result write per neuron
module fc_flatten_dense
  import fc_flatten_dense_pkg::*;
#(
  parameter int NUM_NEURONS = 2,
  parameter bit RELU_EN     = 1'b1
) (
  input logic                clk,
  input logic                reset,
  fc_flatten_dense_if.master bus
);

  localparam logic [9:0] K_LAST = 10'(FEAT_N - 1);
  localparam logic [1:0] N_LAST = 2'(NUM_NEURONS - 1);

  state_e            state_q;
  logic [9:0]        k_q;
  logic [1:0]        n_q;
  logic              busy_q;
  logic              done_q;
  logic              crd_q;
  logic              cwr_q;
  logic [2:0]        csel_q;
  logic [ADDR_W-1:0] caddr_wr_q;
  logic [Q_W-1:0]    cdata_wr_q;
  logic [Q_W-1:0]    mac_result;

  fc_mac_round #(.RELU_EN(RELU_EN)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .issue_i  (crd_q),
    .clear_i  (cwr_q | ~busy_q),
    .feat_i   (bus.cdata_rd),
    .wgt_i    (bus.wdata),
    .bias_i   (bus.bias_data),
    .result_o (mac_result)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crd      = crd_q;
  assign bus.caddr_rd = {2'b00, k_q};
  assign bus.waddr    = {n_q, k_q};
  assign bus.cwr      = cwr_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.csel     = csel_q;

  // Outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= CSEL_OFF;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      done_q <= 1'b0;
      cwr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.ready) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            crd_q   <= 1'b1;
            csel_q  <= CSEL_L1;
            k_q     <= '0;
            n_q     <= '0;
          end
        end
        S_FETCH: begin
          if (k_q == K_LAST) begin
            state_q <= S_DRAIN1;
            crd_q   <= 1'b0;
            csel_q  <= CSEL_OFF;
          end else begin
            k_q <= k_q + 10'd1;
          end
        end
        S_DRAIN1: begin
          state_q <= S_DRAIN2;
        end
        S_DRAIN2: begin
          state_q    <= S_WRITE;
          cwr_q      <= 1'b1;
          csel_q     <= CSEL_L2;
          caddr_wr_q <= {10'b0, n_q};
          cdata_wr_q <= mac_result;
        end
        S_WRITE: begin
          csel_q <= CSEL_OFF;
          if (n_q == N_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            n_q     <= n_q + 2'd1;
            k_q     <= '0;
            crd_q   <= 1'b1;
            csel_q  <= CSEL_L1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_flatten_dense.sv
// tb/tb_fc_flatten_dense.sv - randomized and directed bench for fc_flatten_dense with arithmetic model
module tb_fc_flatten_dense;
  import fc_flatten_dense_pkg::*;

  localparam int NN = 2;

  logic clk;
  logic reset;

  fc_flatten_dense_if b0 ();
  fc_flatten_dense_if b1 ();

  fc_flatten_dense #(.NUM_NEURONS(NN), .RELU_EN(1'b1)) u_dut_relu (.clk(clk), .reset(reset), .bus(b0));
  fc_flatten_dense #(.NUM_NEURONS(NN), .RELU_EN(1'b0)) u_dut_lin  (.clk(clk), .reset(reset), .bus(b1));

  logic [19:0] feat   [1024];
  logic [19:0] wgt    [4][1024];
  logic [19:0] bias_m [4];
  logic [31:0] wq0 [$];
  logic [31:0] wq1 [$];

  int n_tests, n_fail;
  int busy_cyc, done_cnt, rd_cnt, contig_err, overlap, csel_err, nw;
  int base_w0, base_w1, base_busy, base_done, base_rd, base_ce, base_ov, base_cs;
  logic        prev_crd;
  logic [11:0] prev_addr;
  logic [11:0] ra, wa;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign b0.bias_data = bias_m[b0.waddr[11:10]];
  assign b1.bias_data = bias_m[b1.waddr[11:10]];

  // Layer-1 memory and weight ROM: data valid the cycle after the address.
  always begin
    @(negedge clk);
    ra = b0.caddr_rd;
    wa = b0.waddr;
    @(posedge clk);
    #1;
    b0.cdata_rd = feat[ra[9:0]];
    b0.wdata    = wgt[wa[11:10]][wa[9:0]];
    b1.cdata_rd = feat[ra[9:0]];
    b1.wdata    = wgt[wa[11:10]][wa[9:0]];
  end

  initial begin
    busy_cyc = 0; done_cnt = 0; rd_cnt = 0; contig_err = 0; overlap = 0; csel_err = 0; nw = 0;
    prev_crd = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!b0.busy) nw = 0;
      if (b0.busy) busy_cyc++;
      if (b0.done) done_cnt++;
      if (b0.crd) begin
        rd_cnt++;
        if (b0.caddr_rd !== (prev_crd ? prev_addr + 12'd1 : 12'd0) ||
            b0.waddr !== {2'(nw), b0.caddr_rd[9:0]}) contig_err++;
      end
      if (b0.crd && b0.cwr) overlap++;
      if (b0.csel !== (b0.crd ? CSEL_L1 : (b0.cwr ? CSEL_L2 : CSEL_OFF))) csel_err++;
      if (b0.cwr) begin
        wq0.push_back({b0.caddr_wr, b0.cdata_wr});
        nw++;
      end
      if (b1.cwr) wq1.push_back({b1.caddr_wr, b1.cdata_wr});
      prev_crd  = b0.crd;
      prev_addr = b0.caddr_rd;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model(input int n, input bit relu);
    longint acc, r;
    acc = 0;
    for (int k = 0; k < 1024; k++)
      acc += longint'($signed(feat[k])) * longint'($signed(wgt[n][k]));
    r = (acc + longint'($signed(bias_m[n])) * 65536 + 32768) >>> 16;
    if (r > 524287) r = 524287;
    else if (r < -524288) r = -524288;
    if (relu && r < 0) r = 0;
    return r[19:0];
  endfunction

  function automatic logic [31:0] wget(input bit which, input int i);
    if (which == 1'b0) return (i < wq0.size()) ? wq0[i] : 32'hxxxx_xxxx;
    return (i < wq1.size()) ? wq1[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [63:0] outs(input bit which);
    if (which == 1'b0)
      return {1'b0, b0.busy, b0.done, b0.crd, b0.cwr, b0.csel, b0.caddr_rd, b0.caddr_wr, b0.cdata_wr, b0.waddr};
    return {1'b0, b1.busy, b1.done, b1.crd, b1.cwr, b1.csel, b1.caddr_rd, b1.caddr_wr, b1.cdata_wr, b1.waddr};
  endfunction

  task automatic set_all(input logic [19:0] f, input logic [19:0] w, input logic [19:0] b);
    for (int k = 0; k < 1024; k++) begin
      feat[k] = f;
      for (int n = 0; n < 4; n++) wgt[n][k] = w;
    end
    for (int n = 0; n < 4; n++) bias_m[n] = b;
  endtask

  task automatic set_random();
    int sf, sw;
    logic signed [19:0] t;
    sf = $urandom_range(0, 9);
    sw = $urandom_range(0, 9);
    for (int k = 0; k < 1024; k++) begin
      t = 20'($urandom);
      feat[k] = 20'(t >>> sf);
      for (int n = 0; n < 4; n++) begin
        t = 20'($urandom);
        wgt[n][k] = 20'(t >>> sw);
      end
    end
    for (int n = 0; n < 4; n++) bias_m[n] = 20'($urandom);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1;
    b0.ready = 1'b1; b1.ready = 1'b1;
    @(posedge clk); #1;
    b0.ready = 1'b0; b1.ready = 1'b0;
  endtask

  task automatic run_pass(input bit extra_ready);
    int cyc;
    base_w0 = wq0.size(); base_w1 = wq1.size();
    base_busy = busy_cyc; base_done = done_cnt; base_rd = rd_cnt;
    base_ce = contig_err; base_ov = overlap; base_cs = csel_err;
    pulse_ready();
    if (extra_ready) begin
      repeat (100) @(posedge clk);
      pulse_ready();
    end
    cyc = 0;
    while (done_cnt == base_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 4000) check_eq("pass_timeout", 64'(done_cnt - base_done), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, "_cnt_relu"}, 64'(wq0.size() - base_w0), 64'(NN));
    check_eq({tag, "_cnt_lin"},  64'(wq1.size() - base_w1), 64'(NN));
    for (int i = 0; i < NN; i++) begin
      check_eq($sformatf("%s_relu_n%0d", tag, i), 64'(wget(1'b0, base_w0 + i)), 64'({12'(i), model(i, 1'b1)}));
      check_eq($sformatf("%s_lin_n%0d",  tag, i), 64'(wget(1'b1, base_w1 + i)), 64'({12'(i), model(i, 1'b0)}));
    end
  endtask

  task automatic check_timing(input string tag);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cyc - base_busy), 64'(1027 * NN + 1));
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - base_done), 64'd1);
    check_eq({tag, "_reads"},       64'(rd_cnt - base_rd),     64'(1024 * NN));
    check_eq({tag, "_addr_walk"},   64'(contig_err - base_ce), 64'd0);
    check_eq({tag, "_rd_wr_overlap"}, 64'(overlap - base_ov),  64'd0);
    check_eq({tag, "_csel"},        64'(csel_err - base_cs),   64'd0);
  endtask

  task automatic check_lit(input string tag, input bit which, input int idx, input logic [19:0] exp);
    logic [31:0] w;
    w = wget(which, idx);
    check_eq(tag, 64'(w[19:0]), 64'(exp));
  endtask

  initial begin
    int cyc;
    n_tests = 0; n_fail = 0;
    reset = 1'b0;
    b0.ready = 1'b0; b1.ready = 1'b0;
    set_all(20'h0, 20'h0, 20'h0);
    repeat (3) @(negedge clk);
    check_eq("reset_relu", outs(1'b0), 64'd0);
    check_eq("reset_lin",  outs(1'b1), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    set_all(20'h0, 20'h0, 20'h01310);
    for (int k = 0; k < 1024; k++) for (int n = 0; n < 4; n++) wgt[n][k] = 20'($urandom);
    run_pass(1'b1);
    check_writes("s1");
    check_timing("s1");
    check_lit("s1_lit_n1", 1'b0, base_w0 + 1, 20'h01310);
    check_eq("s1_no_restart", 64'(b0.busy), 64'd0);

    set_all(20'h0, 20'h0, 20'h0);
    feat[0] = 20'h10000; wgt[0][0] = 20'h08000; wgt[1][0] = 20'h08000;
    run_pass(1'b0);
    check_writes("s2");
    check_lit("s2_lit", 1'b0, base_w0, 20'h08000);

    set_all(20'h0, 20'h0, 20'h0);
    feat[5] = 20'h00001; wgt[0][5] = 20'h08000; wgt[1][5] = 20'h08000;
    run_pass(1'b0);
    check_writes("s3");
    check_lit("s3_lit", 1'b0, base_w0, 20'h00001);

    set_all(20'h7FFFF, 20'h7FFFF, 20'h0);
    run_pass(1'b0);
    check_writes("s4_pos");
    check_lit("s4_pos_lit", 1'b1, base_w1, 20'h7FFFF);

    set_all(20'h7FFFF, 20'h80001, 20'h0);
    run_pass(1'b0);
    check_writes("s4_neg");
    check_lit("s4_neg_relu_lit", 1'b0, base_w0, 20'h00000);
    check_lit("s4_neg_lin_lit",  1'b1, base_w1, 20'h80000);

    for (int p = 0; p < 4; p++) begin
      set_random();
      run_pass(1'b0);
      check_writes($sformatf("rnd%0d", p));
      check_timing($sformatf("rnd%0d", p));
    end

    set_all(20'h0, 20'h0, 20'h01310);
    for (int k = 0; k < 1024; k++) for (int n = 0; n < 4; n++) wgt[n][k] = 20'($urandom);
    base_w0 = wq0.size();
    pulse_ready();
    cyc = 0;
    while (!(b0.crd && b0.caddr_rd == 12'd500 && b0.waddr[11:10] == 2'd0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("s6_reach_500", 64'(b0.caddr_rd), 64'd500);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("s6_rst_relu", outs(1'b0), 64'd0);
    check_eq("s6_rst_lin",  outs(1'b1), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("s6_no_write", 64'(wq0.size() - base_w0), 64'd0);
    check_eq("s6_idle", 64'(b0.busy), 64'd0);
    run_pass(1'b0);
    check_writes("s6");
    check_timing("s6");
    check_lit("s6_lit_n0", 1'b0, base_w0, 20'h01310);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
